instr_mem: RTL

- Instruction-memory responder for the core's fetch port.
- Accepts a program as a valid/ready byte stream (LOAD), then serves the core's `instr_addr` requests with registered `instr_data` (RUN).
- Drives `last_pc` so the core holds its PC while loading and halts at the final loaded word.

---
 rtl/instr_mem_pkg.sv | 15 +
 rtl/instr_mem_byte_packer.sv | 46 ++++
 rtl/instr_mem.sv | 124 ++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   state_t       : LOAD/RUN state encoding
//   NOP_INSTR     : addi x0,x0,0, default word for unloaded/out-of-range fetches
//   LAST_PC_IDLE  : last_pc value while no program is loaded (core reset PC)
package instr_mem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] LAST_PC_IDLE = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_mem_byte_packer.sv
// Packs accepted loader bytes little-endian into 32-bit words.
//   clk, rst    : clock, synchronous active-high clear (also used for reload)
//   byte_valid  : a byte is accepted this cycle
//   byte_data   : accepted byte
//   byte_last   : accepted byte is the final program byte
//   word_valid  : combinational, word completes on this edge (4th byte or last)
//   word_data   : combinational, assembled word, unfilled upper bytes zero
//   word_last   : combinational, completed word closes the program
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic        word_last
);

    logic [1:0]  byte_idx;
    logic [23:0] acc;

    // Word is presented in the same cycle as its final byte so the array write lands on that edge.
    always_comb begin
        word_valid = byte_valid && ((byte_idx == 2'd3) || byte_last);
        word_last  = byte_valid && byte_last;
        word_data  = {8'h00, acc} | (32'(byte_data) << {byte_idx, 3'b000});
    end

    // acc is cleared after every word so a short last word is zero-padded.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= 2'd0;
            acc      <= 24'd0;
        end else if (byte_valid) begin
            if (word_valid) begin
                byte_idx <= 2'd0;
                acc      <= 24'd0;
            end else begin
                acc      <= acc | (24'(byte_data) << {byte_idx, 3'b000});
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Instruction-memory responder: loads a program from a byte stream, then
// serves registered word fetches to the core.
// Optional macro INSTR_MEM_RELOAD_EN adds a 'reload' input returning RUN to LOAD.
//   clk, rst          : clock, synchronous active-high reset
//   load_valid/ready  : loader byte handshake (ready exactly in LOAD)
//   load_byte         : program byte, little-endian within a word
//   load_last         : final program byte
//   instr_addr        : word address of the next fetch
//   instr_data        : registered fetch result
//   last_pc           : final loaded word address (all ones while loading)
//   running           : high in RUN
//   overflow          : sticky, program exceeded the memory depth
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] NOP_WORD   = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
`ifdef INSTR_MEM_RELOAD_EN
    input  logic        reload,
`endif
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic [31:0] last_pc,
    output logic        running,
    output logic        overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  word_count;     // doubles as write pointer; saturates at DEPTH
    logic           accept;
    logic           reload_fire;
    logic           full;
    logic           in_range;
    logic           word_valid;
    logic           word_last;
    logic [31:0]    word_data;
    logic [31:0]    mem [DEPTH];

    assign accept = load_valid && load_ready;
    assign full   = word_count[DEPTH_LOG2];

`ifdef INSTR_MEM_RELOAD_EN
    assign reload_fire = (state == ST_RUN) && reload;
`else
    assign reload_fire = 1'b0;
`endif

    // Any address bit at or above DEPTH_LOG2 is out of range, as is anything not yet written.
    assign in_range = ((instr_addr >> DEPTH_LOG2) == 32'd0) && (CW'(instr_addr) < word_count);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst || reload_fire),
        .byte_valid (accept),
        .byte_data  (load_byte),
        .byte_last  (load_last),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last)
    );

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: if (accept && load_last) state_next = ST_RUN;
            ST_RUN:  if (reload_fire)         state_next = ST_LOAD;
            default:                          state_next = ST_LOAD;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            load_ready <= 1'b1;
            running    <= 1'b0;
            instr_data <= NOP_WORD;
            last_pc    <= LAST_PC_IDLE;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_next;
            load_ready <= (state_next == ST_LOAD);
            running    <= (state_next == ST_RUN);
            if (reload_fire) begin
                word_count <= '0;
                overflow   <= 1'b0;
                last_pc    <= LAST_PC_IDLE;
                instr_data <= NOP_WORD;
            end else begin
                if (word_valid) begin
                    if (full) overflow   <= 1'b1;
                    else      word_count <= word_count + CW'(1);
                end
                // Index of the last stored word, counting the one written on this edge.
                if (word_last) begin
                    last_pc <= full ? 32'(word_count - CW'(1)) : 32'(word_count);
                end
                instr_data <= ((state == ST_RUN) && in_range)
                              ? mem[instr_addr[DEPTH_LOG2-1:0]] : NOP_WORD;
            end
        end
    end

    // Program array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && word_valid && !full) begin
            mem[word_count[DEPTH_LOG2-1:0]] <= word_data;
        end
    end

endmodule
